// File: rtl/vpu_dispatch_scheduler.sv
// VPU dispatch scheduler: scoreboard hazard check, per-FU in-flight limiting and VCFG drain.
// Define VPU_SB_WB_BYPASS_EN to let a same-cycle writeback release a dependent instruction.
module vpu_dispatch_scheduler #(
    parameter int unsigned NUM_FU       = 4,
    parameter int unsigned FU_BITS      = 2,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_BITS     = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dispatch_entry_valid_i,
    input  logic [FU_BITS-1:0]  entry_fu_i,
    input  logic [4:0]          entry_vd_i,
    input  logic [4:0]          entry_vs1_i,
    input  logic [4:0]          entry_vs2_i,
    input  logic                entry_wr_vd_i,
    input  logic                entry_rd_vs1_i,
    input  logic                entry_rd_vs2_i,
    output logic                dispatch_ack_o,
    output logic [NUM_FU-1:0]   issue_valid_o,
    input  logic [NUM_FU-1:0]   issue_ready_i,
    input  logic [NUM_FU-1:0]   fu_done_i,
    input  logic                wb_valid_i,
    input  logic [4:0]          wb_vd_i,
    input  logic                drain_i,
    output logic                drain_done_o,
    output logic [31:0]         sb_busy_o
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_INFLIGHT);

    state_t              state;
    logic [31:0]         busy;
    logic [CNT_BITS-1:0] cnt [NUM_FU];

    logic [31:0]         wb_mask;
    logic [31:0]         set_mask;
    logic [31:0]         busy_chk;
    logic [NUM_FU-1:0]   inc_vec;
    logic                hazard;
    logic                fu_full;
    logic                fire;
    logic                pipe_empty;

    always_comb begin
        wb_mask = '0;
        if (wb_valid_i) wb_mask[wb_vd_i] = 1'b1;
    end

`ifdef VPU_SB_WB_BYPASS_EN
    assign busy_chk = busy & ~wb_mask;
`else
    assign busy_chk = busy;
`endif

    assign hazard = (entry_rd_vs1_i & busy_chk[entry_vs1_i])
                  | (entry_rd_vs2_i & busy_chk[entry_vs2_i])
                  | (entry_wr_vd_i  & busy_chk[entry_vd_i]);

    assign fu_full = (cnt[entry_fu_i] == CNT_MAX);

    // Issue request is formed without looking at ready, so FUs may wait on valid.
    always_comb begin
        issue_valid_o = '0;
        if (dispatch_entry_valid_i && (state == ST_RUN) && !drain_i && !hazard && !fu_full)
            issue_valid_o[entry_fu_i] = 1'b1;
    end

    assign inc_vec        = issue_valid_o & issue_ready_i;
    assign fire           = |inc_vec;
    assign dispatch_ack_o = fire;

    always_comb begin
        set_mask = '0;
        if (fire && entry_wr_vd_i) set_mask[entry_vd_i] = 1'b1;
    end

    // Set is applied after clear so a new writer keeps the register reserved.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) busy <= '0;
        else       busy <= (busy & ~wb_mask) | set_mask;
    end

    assign sb_busy_o = busy;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned f = 0; f < NUM_FU; f++) cnt[f] <= '0;
        end else begin
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                if (inc_vec[f] && !fu_done_i[f] && (cnt[f] != CNT_MAX))
                    cnt[f] <= cnt[f] + 1'b1;
                else if (fu_done_i[f] && !inc_vec[f] && (cnt[f] != '0))
                    cnt[f] <= cnt[f] - 1'b1;
            end
        end
    end

    always_comb begin
        pipe_empty = (busy == '0);
        for (int unsigned f = 0; f < NUM_FU; f++)
            if (cnt[f] != '0) pipe_empty = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_RUN;
            drain_done_o <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    drain_done_o <= 1'b0;
                    if (drain_i) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!drain_i) begin
                        state <= ST_RUN;
                    end else if (pipe_empty) begin
                        state        <= ST_DONE;
                        drain_done_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state        <= ST_RUN;
                    drain_done_o <= 1'b0;
                end
                default: begin
                    state        <= ST_RUN;
                    drain_done_o <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_FU; g++) begin : g_cnt_chk
        a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(fu_done_i[g] && !inc_vec[g] && (cnt[g] == '0)));
        a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(inc_vec[g] && !fu_done_i[g] && (cnt[g] == CNT_MAX)));
    end

endmodule

// File: tb/tb_vpu_dispatch_scheduler.sv
// Directed bench for vpu_dispatch_scheduler with a per-cycle reference model.
module tb_vpu_dispatch_scheduler;
    localparam int NF   = 4;
    localparam int MAXI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  fu;
    logic [4:0]  vd, vs1, vs2;
    logic        wr, r1, r2;
    logic        ack;
    logic [3:0]  iv;
    logic [3:0]  ready;
    logic [3:0]  fu_done;
    logic        wb_valid;
    logic [4:0]  wb_vd;
    logic        drain;
    logic        drain_done;
    logic [31:0] sb_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vpu_dispatch_scheduler #(
        .NUM_FU(4), .FU_BITS(2), .MAX_INFLIGHT(3), .CNT_BITS(3)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .dispatch_entry_valid_i(valid), .entry_fu_i(fu),
        .entry_vd_i(vd), .entry_vs1_i(vs1), .entry_vs2_i(vs2),
        .entry_wr_vd_i(wr), .entry_rd_vs1_i(r1), .entry_rd_vs2_i(r2),
        .dispatch_ack_o(ack), .issue_valid_o(iv), .issue_ready_i(ready),
        .fu_done_i(fu_done), .wb_valid_i(wb_valid), .wb_vd_i(wb_vd),
        .drain_i(drain), .drain_done_o(drain_done), .sb_busy_o(sb_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: scoreboard set, outstanding op counts, drain progress.
    bit [31:0] m_busy;
    int        m_cnt [NF];
    bit        m_drain;
    bit        m_pulse;

    always @(negedge clk) begin : model
        bit [31:0] eff;
        bit        hz, full, emp, mfire;
        logic [3:0] eiv;
        if (rst) begin
            m_busy = '0; m_drain = 0; m_pulse = 0;
            for (int f = 0; f < NF; f++) m_cnt[f] = 0;
            check("rst_busy", sb_busy, 32'h0);
            check("rst_done", {31'b0, drain_done}, 32'h0);
        end else begin
            eff = m_busy;
`ifdef VPU_SB_WB_BYPASS_EN
            if (wb_valid) eff[wb_vd] = 1'b0;
`endif
            hz   = (r1 && eff[vs1]) || (r2 && eff[vs2]) || (wr && eff[vd]);
            full = m_cnt[fu] >= MAXI;
            eiv  = '0;
            if (valid && !m_drain && !m_pulse && !drain && !hz && !full) eiv[fu] = 1'b1;
            mfire = (eiv & ready) != 4'b0;
            check("m_issue_valid", {28'b0, iv}, {28'b0, eiv});
            check("m_ack", {31'b0, ack}, {31'b0, mfire});
            check("m_drain_done", {31'b0, drain_done}, {31'b0, m_pulse});
            check("m_sb_busy", sb_busy, m_busy);

            emp = (m_busy == 0);
            for (int f = 0; f < NF; f++) if (m_cnt[f] != 0) emp = 0;

            if (wb_valid) m_busy[wb_vd] = 1'b0;
            if (mfire && wr) m_busy[vd] = 1'b1;
            for (int f = 0; f < NF; f++) begin
                m_cnt[f] = m_cnt[f] + ((mfire && fu == 2'(f)) ? 1 : 0) - (fu_done[f] ? 1 : 0);
                if (m_cnt[f] < 0) m_cnt[f] = 0;
                if (m_cnt[f] > MAXI) m_cnt[f] = MAXI;
            end

            if (m_pulse) m_pulse = 0;
            else if (m_drain) begin
                if (!drain) m_drain = 0;
                else if (emp) begin m_drain = 0; m_pulse = 1; end
            end else if (drain) m_drain = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic w, input logic u1, input logic u2);
        valid = 1'b1; fu = f; vd = d; vs1 = s1; vs2 = s2; wr = w; r1 = u1; r2 = u2;
    endtask

    task automatic quiet();
        valid = 1'b0; wr = 1'b0; r1 = 1'b0; r2 = 1'b0; wb_valid = 1'b0; fu_done = '0;
    endtask

    // Retire everything the model says is outstanding, one register per cycle.
    task automatic cleanup();
        for (int i = 0; i < 40; i++) begin
            bit work;
            quiet();
            work = 0;
            for (int f = 0; f < NF; f++) if (m_cnt[f] > 0) begin fu_done[f] = 1'b1; work = 1; end
            for (int r = 0; r < 32; r++) if (m_busy[r]) begin wb_valid = 1'b1; wb_vd = 5'(r); work = 1; end
            if (!work) break;
            tick();
        end
        quiet();
        #1 check("cleanup_busy", sb_busy, 32'h0);
        tick();
    endtask

    initial begin
        rst = 1'b1; drain = 1'b0; ready = '0; wb_vd = '0;
        fu = '0; vd = '0; vs1 = '0; vs2 = '0;
        quiet();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", sb_busy, 32'h0);
        check("reset_done", {31'b0, drain_done}, 32'h0);
        check("reset_iv_idle", {28'b0, iv}, 32'h0);
        rst = 1'b0;
        tick();

        // Scenario 1: basic issue reserving v3 on FU1.
        head(2'd1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); ready = 4'b0010;
        #1 check("s1_iv", {28'b0, iv}, 32'h2);
        check("s1_ack", {31'b0, ack}, 32'h1);
        tick();
        quiet();
        #1 check("s1_busy", sb_busy, 32'h8);
        tick();

        // Scenario 2: RAW on v3 released by writeback.
        ready = 4'b1111;
        head(2'd2, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0);
        #1 check("s2_hold", {28'b0, iv}, 32'h0);
        tick();
        wb_valid = 1'b1; wb_vd = 5'd3;
`ifdef VPU_SB_WB_BYPASS_EN
        #1 check("s2_wb_cycle", {28'b0, iv}, 32'h4);
        tick();
        wb_valid = 1'b0; valid = 1'b0;
`else
        #1 check("s2_wb_cycle", {28'b0, iv}, 32'h0);
        tick();
        wb_valid = 1'b0;
        #1 check("s2_next_cycle", {28'b0, iv}, 32'h4);
        tick();
        valid = 1'b0;
`endif
        #1 check("s2_busy", sb_busy, 32'h0);
        cleanup();

        // Scenario 3: in-flight limit on FU0.
        head(2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); ready = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            #1 check("s3_iv", {28'b0, iv}, (i < 3) ? 32'h1 : 32'h0);
            tick();
        end
        fu_done = 4'b0001;
        #1 check("s3_full", {28'b0, iv}, 32'h0);
        tick();
        fu_done = '0;
        #1 check("s3_resume", {28'b0, iv}, 32'h1);
        tick();
        cleanup();

        // Scenario 4: issue writing v5 in the same cycle as v5 writeback.
        head(2'd3, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); ready = 4'b1000;
        #1 check("s4_first", {28'b0, iv}, 32'h8);
        tick();
        wb_valid = 1'b1; wb_vd = 5'd5;
`ifdef VPU_SB_WB_BYPASS_EN
        #1 check("s4_iv", {28'b0, iv}, 32'h8);
        tick();
        quiet();
        #1 check("s4_busy", sb_busy, 32'h20);
`else
        #1 check("s4_iv", {28'b0, iv}, 32'h0);
        tick();
        quiet();
        #1 check("s4_busy", sb_busy, 32'h0);
`endif
        cleanup();

        // Scenario 5: drain with v7 busy and FU2 outstanding.
        head(2'd2, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); ready = 4'b0100;
        #1 check("s5_setup", {28'b0, iv}, 32'h4);
        tick();
        head(2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); ready = 4'b1111; drain = 1'b1;
        #1 check("s5_no_issue", {28'b0, iv}, 32'h0);
        tick();
        #1 check("s5_drain_iv", {28'b0, iv}, 32'h0);
        check("s5_drain_wait", {31'b0, drain_done}, 32'h0);
        tick();
        wb_valid = 1'b1; wb_vd = 5'd7; fu_done = 4'b0100;
        #1 check("s5_retire", {31'b0, drain_done}, 32'h0);
        tick();
        wb_valid = 1'b0; fu_done = '0;
        #1 check("s5_pre_pulse", {31'b0, drain_done}, 32'h0);
        tick();
        #1 check("s5_pulse", {31'b0, drain_done}, 32'h1);
        check("s5_pulse_iv", {28'b0, iv}, 32'h0);
        drain = 1'b0;
        tick();
        #1 check("s5_post_pulse", {31'b0, drain_done}, 32'h0);
        check("s5_resume", {28'b0, iv}, 32'h1);
        tick();
        cleanup();

        // Early drain withdrawal: no pulse.
        head(2'd1, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); ready = 4'b0010;
        tick();
        quiet(); drain = 1'b1;
        tick();
        tick();
        drain = 1'b0;
        #1 check("early_drop", {31'b0, drain_done}, 32'h0);
        tick();
        #1 check("early_drop_after", {31'b0, drain_done}, 32'h0);
        cleanup();

        // Scenario 6: asynchronous reset during drain.
        head(2'd1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); ready = 4'b0010;
        tick();
        quiet(); drain = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1 check("s6_busy", sb_busy, 32'h0);
        check("s6_done", {31'b0, drain_done}, 32'h0);
        drain = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        head(2'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); ready = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            #1 check("s6_cnt_cleared", {28'b0, iv}, (i < 3) ? 32'h2 : 32'h0);
            tick();
        end
        cleanup();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
